// File: rtl/instruction_rom_loader.sv
`timescale 1ns/1ps
// Instruction memory for the fetch stage. A program is streamed in through the
// load port while in LOAD mode. The block then switches to RUN and serves
// registered fetches with a one-cycle latency and a stall hold.
module instruction_rom_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 110,
  parameter int                    ADDR_WIDTH = 20,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  stall,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  addr_fault,
  output logic                  running,
  output logic [ADDR_WIDTH-1:0] load_count
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   load_ptr;
  logic                    load_write;
  logic                    clear_load;
  logic                    fetch_accept;
  logic                    hold_resp;
  logic                    fetch_in_range;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // The write pointer and the word count always move together, so one
  // register serves both.
  assign load_count     = load_ptr;
  assign fetch_in_range = (fetch_addr < DEPTH_A);

  // Mode register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_next;
  end

  // Next-state and handshake decode; reload outranks any fetch activity.
  always_comb begin
    state_next   = state;
    load_ready   = 1'b0;
    fetch_ready  = 1'b0;
    running      = 1'b0;
    load_write   = 1'b0;
    clear_load   = 1'b0;
    fetch_accept = 1'b0;
    hold_resp    = 1'b0;
    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_write = 1'b1;
          if (load_last || (load_ptr == LAST_ADDR)) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (reload) begin
          state_next = ST_LOAD;
          clear_load = 1'b1;
        end else begin
          fetch_ready  = ~stall | ~instr_valid;
          fetch_accept = fetch_ready & fetch_req;
          hold_resp    = stall & instr_valid;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  // Load pointer: advances per accepted load word, restarts on reload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           load_ptr <= '0;
    else if (clear_load) load_ptr <= '0;
    else if (load_write) load_ptr <= load_ptr + ADDR_WIDTH'(1);
  end

  // Program storage; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (load_write && (load_ptr < DEPTH_A)) mem[load_ptr[IDX_W-1:0]] <= load_data;
  end

  // Fetch response register: new word on accept, frozen while stalled, else invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else if (fetch_accept) begin
      instr_valid <= 1'b1;
      if (fetch_in_range) begin
        instruction <= mem[fetch_addr[IDX_W-1:0]];
        addr_fault  <= 1'b0;
      end else begin
        instruction <= NOP_WORD;
        addr_fault  <= 1'b1;
      end
    end else if (!hold_resp) begin
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_rom_loader.sv
`timescale 1ns/1ps
// Self-checking bench for instruction_rom_loader: directed scenarios followed
// by randomized traffic, all compared against a behavioural program model.
module tb_instruction_rom_loader;

  localparam int          DW    = 32;
  localparam int          AW    = 20;
  localparam int          DEPTH = 110;
  localparam int          SDEP  = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
  logic          fetch_req = 1'b0, stall = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] fetch_addr = '0;
  logic          load_ready, fetch_ready, instr_valid, addr_fault, running;
  logic [DW-1:0] instruction;
  logic [AW-1:0] load_count;

  logic          s_load_valid = 1'b0, s_load_last = 1'b0, s_reload = 1'b0;
  logic          s_fetch_req = 1'b0, s_stall = 1'b0;
  logic [DW-1:0] s_load_data = '0;
  logic [AW-1:0] s_fetch_addr = '0;
  logic          s_load_ready, s_fetch_ready, s_instr_valid, s_addr_fault, s_running;
  logic [DW-1:0] s_instruction;
  logic [AW-1:0] s_load_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the program image plus the visible response.
  logic [31:0] m_mem [DEPTH];
  bit          m_running;
  int          m_count;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_fault;

  always #5 clock = ~clock;

  instruction_rom_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .reload(reload), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .fetch_ready(fetch_ready), .instruction(instruction), .instr_valid(instr_valid),
    .addr_fault(addr_fault), .running(running), .load_count(load_count)
  );

  instruction_rom_loader #(.DATA_WIDTH(DW), .DEPTH(SDEP), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut_small (
    .clock(clock), .reset(reset),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last), .load_ready(s_load_ready),
    .reload(s_reload), .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .stall(s_stall),
    .fetch_ready(s_fetch_ready), .instruction(s_instruction), .instr_valid(s_instr_valid),
    .addr_fault(s_addr_fault), .running(s_running), .load_count(s_load_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "/running"},     32'(running),     32'(m_running));
    check({tag, "/load_count"},  32'(load_count),  32'(m_count));
    check({tag, "/instr_valid"}, 32'(instr_valid), 32'(m_valid));
    check({tag, "/addr_fault"},  32'(addr_fault),  32'(m_fault));
    check({tag, "/instruction"}, instruction,      m_instr);
  endtask

  // One clock of the reference rules, applied to the inputs seen at the edge.
  task automatic modelStep(input bit lv, input logic [31:0] ld, input bit ll,
                           input bit rl, input bit fr, input int fa, input bit st);
    if (!m_running) begin
      if (lv) begin
        m_mem[m_count] = ld;
        m_count++;
        if (ll || m_count == DEPTH) m_running = 1;
      end
      m_valid = 0;
      m_fault = 0;
    end else if (rl) begin
      m_running = 0;
      m_count   = 0;
      m_valid   = 0;
      m_fault   = 0;
    end else if (st && m_valid) begin
      m_valid = 1;
    end else if (fr) begin
      m_valid = 1;
      if (fa >= DEPTH) begin
        m_instr = NOP;
        m_fault = 1;
      end else begin
        m_instr = m_mem[fa];
        m_fault = 0;
      end
    end else begin
      m_valid = 0;
      m_fault = 0;
    end
  endtask

  task automatic applyStimulus(input string tag, input bit lv, input logic [31:0] ld, input bit ll,
                               input bit rl, input bit fr, input int fa, input bit st);
    load_valid = lv; load_data = ld; load_last = ll; reload = rl;
    fetch_req = fr; fetch_addr = AW'(fa); stall = st;
    #1;
    check({tag, "/load_ready"},  32'(load_ready),  32'(!m_running));
    check({tag, "/fetch_ready"}, 32'(fetch_ready), 32'(m_running && !rl && (!st || !m_valid)));
    @(posedge clock);
    #1;
    modelStep(lv, ld, ll, rl, fr, fa, st);
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    #2;
    load_valid = 0; load_last = 0; reload = 0; fetch_req = 0; stall = 0;
    s_load_valid = 0; s_load_last = 0; s_reload = 0; s_fetch_req = 0; s_stall = 0;
    check({tag, "/running"},     32'(running),     32'd0);
    check({tag, "/load_ready"},  32'(load_ready),  32'd1);
    check({tag, "/fetch_ready"}, 32'(fetch_ready), 32'd0);
    check({tag, "/instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "/addr_fault"},  32'(addr_fault),  32'd0);
    check({tag, "/load_count"},  32'(load_count),  32'd0);
    check({tag, "/instruction"}, instruction,      32'd0);
    check({tag, "/s_running"},   32'(s_running),   32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_running = 0; m_count = 0; m_instr = '0; m_valid = 0; m_fault = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // T1: reset state.
    doReset("T1");

    // T3: auto-full on the DEPTH=4 instance; the main instance idles in LOAD.
    for (int i = 0; i < SDEP; i++) begin
      s_load_valid = 1; s_load_data = 32'hB000_0000 + 32'(i); s_load_last = 0;
      @(posedge clock);
      #1;
      check("T3/s_running", 32'(s_running), 32'((i == SDEP - 1) ? 1 : 0));
      check("T3/s_load_count", 32'(s_load_count), 32'(i + 1));
    end
    s_load_data = 32'hDEAD_BEEF;
    #1;
    check("T3/s_load_ready", 32'(s_load_ready), 32'd0);
    @(posedge clock);
    #1;
    s_load_valid = 0;
    check("T3/s_count_after5", 32'(s_load_count), 32'(SDEP));
    for (int i = 0; i < SDEP; i++) begin
      s_fetch_req = 1; s_fetch_addr = AW'(i);
      @(posedge clock);
      #1;
      check("T3/s_word", s_instruction, 32'hB000_0000 + 32'(i));
    end
    s_fetch_req = 0;

    // T2: load three words and fetch address 1.
    applyStimulus("T2/w0", 1, 32'hA000_0001, 0, 0, 0, 0, 0);
    applyStimulus("T2/w1", 1, 32'hA000_0002, 0, 0, 0, 0, 0);
    applyStimulus("T2/w2", 1, 32'hA000_0003, 1, 0, 0, 0, 0);
    check("T2/running", 32'(running), 32'd1);
    check("T2/load_count", 32'(load_count), 32'd3);
    applyStimulus("T2/fetch1", 0, 0, 0, 0, 1, 1, 0);
    check("T2/instr", instruction, 32'hA000_0002);
    check("T2/valid", 32'(instr_valid), 32'd1);

    // T4: out-of-range fetch returns the NOP word with a fault.
    applyStimulus("T4/fetch110", 0, 0, 0, 0, 1, DEPTH, 0);
    check("T4/instr", instruction, NOP);
    check("T4/fault", 32'(addr_fault), 32'd1);
    check("T4/valid", 32'(instr_valid), 32'd1);

    // T5: stall holds the addr-0 response; addr 2 follows once stall drops.
    applyStimulus("T5/fetch0", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("T5/stall", 0, 0, 0, 0, 1, 2, 1);
      check("T5/held", instruction, 32'hA000_0001);
    end
    applyStimulus("T5/release", 0, 0, 0, 0, 1, 2, 0);
    check("T5/addr2", instruction, 32'hA000_0003);
    check("T5/valid", 32'(instr_valid), 32'd1);

    // T6: reload beats a same-cycle fetch, then reset abandons a partial load.
    applyStimulus("T6/reload", 0, 0, 0, 1, 1, 1, 0);
    check("T6/valid", 32'(instr_valid), 32'd0);
    check("T6/running", 32'(running), 32'd0);
    applyStimulus("T6/part0", 1, 32'h1111_1111, 0, 0, 0, 0, 0);
    load_valid = 1; load_data = 32'h3333_3333;
    doReset("T6/reset");
    applyStimulus("T6/new0", 1, 32'h2222_2222, 1, 0, 0, 0, 0);
    applyStimulus("T6/fetch0", 0, 0, 0, 0, 1, 0, 0);
    check("T6/word0", instruction, 32'h2222_2222);
    check("T6/count", 32'(load_count), 32'd1);

    // Randomized: fill the whole array (auto-full), then mixed traffic.
    applyStimulus("R/reload", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("R/fill", 1, $urandom, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      applyStimulus("R/mix", 1'($urandom % 2), $urandom, 1'(($urandom % 10) == 0),
                    1'(($urandom % 25) == 0), 1'(($urandom % 4) != 0),
                    int'($urandom % (DEPTH + 10)), 1'(($urandom % 3) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
